// File: rtl/mantissa_shift_add_multiplier.sv
// Sequential 24x24 mantissa multiplier for IEEE-754 single operands: one shift-add
// iteration per clock, with the sign and the de-biased exponent sum produced alongside.
module mantissa_shift_add_multiplier #(
    parameter int D_WIDTH = 32,
    parameter int M_WIDTH = 23,
    parameter int E_WIDTH = 8,
    parameter int M       = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   floating1_in,
    input  logic [D_WIDTH-1:0]   floating2_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M-1:0]         product_out,
    output logic [E_WIDTH:0]     exp_sum_out,
    output logic                 sign_out
);

    localparam int MB_W = M_WIDTH + 1;
    localparam int X_W  = E_WIDTH + 1;
    // Adding 2^X_W - bias is the same as subtracting the bias modulo 2^X_W.
    localparam logic [X_W-1:0] BIAS_NEG = X_W'((1 << X_W) - ((1 << (E_WIDTH - 1)) - 1));
    localparam logic [4:0]     LAST_IT  = 5'(MB_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [M-1:0]       mcand_q,   mcand_d;
    logic [MB_W-1:0]    mplier_q,  mplier_d;
    logic [M-1:0]       acc_q,     acc_d;
    logic [4:0]         cnt_q,     cnt_d;
    logic [M-1:0]       product_q, product_d;
    logic [X_W-1:0]     exp_sum_q, exp_sum_d;
    logic               sign_q,    sign_d;
    logic [M-1:0]       acc_add_s;

    logic               sign_a_s, sign_b_s;
    logic [E_WIDTH-1:0] exp_a_s,  exp_b_s;
    logic [M_WIDTH-1:0] man_a_s,  man_b_s;

    assign sign_a_s = floating1_in[D_WIDTH-1];
    assign sign_b_s = floating2_in[D_WIDTH-1];
    assign exp_a_s  = floating1_in[D_WIDTH-2 -: E_WIDTH];
    assign exp_b_s  = floating2_in[D_WIDTH-2 -: E_WIDTH];
    assign man_a_s  = floating1_in[M_WIDTH-1:0];
    assign man_b_s  = floating2_in[M_WIDTH-1:0];

    // Next-state logic: capture in IDLE, one shift-add step per BUSY cycle, hold in DONE.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        exp_sum_d = exp_sum_q;
        sign_d    = sign_q;
        acc_add_s = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d   = {{(M - MB_W){1'b0}}, 1'b1, man_a_s};
                    mplier_d  = {1'b1, man_b_s};
                    acc_d     = {M{1'b0}};
                    cnt_d     = 5'd0;
                    sign_d    = sign_a_s ^ sign_b_s;
                    exp_sum_d = {1'b0, exp_a_s} + {1'b0, exp_b_s} + BIAS_NEG;
                    state_d   = BUSY;
                end else begin
                    state_d   = IDLE;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_add_s = acc_q + mcand_q;
                end else begin
                    acc_add_s = acc_q;
                end
                acc_d    = acc_add_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_IT) begin
                    product_d = acc_add_s;
                    state_d   = DONE;
                end else begin
                    state_d   = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= {M{1'b0}};
            mplier_q  <= {MB_W{1'b0}};
            acc_q     <= {M{1'b0}};
            cnt_q     <= 5'd0;
            product_q <= {M{1'b0}};
            exp_sum_q <= {X_W{1'b0}};
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            exp_sum_q <= exp_sum_d;
            sign_q    <= sign_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign product_out = product_q;
    assign exp_sum_out = exp_sum_q;
    assign sign_out    = sign_q;

endmodule

// File: tb/tb_mantissa_shift_add_multiplier.sv
// Directed bench for mantissa_shift_add_multiplier with hand-computed expected results.
module tb_mantissa_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floating1_in;
    logic [31:0] floating2_in;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] product_out;
    logic [8:0]  exp_sum_out;
    logic        sign_out;

    int n_checks;
    int n_pass;
    int lat;

    mantissa_shift_add_multiplier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .floating1_in (floating1_in),
        .floating2_in (floating2_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product_out  (product_out),
        .exp_sum_out  (exp_sum_out),
        .sign_out     (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
        floating1_in = a;
        floating2_in = b;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd24);
    endtask

    task automatic check_result(input string tag, input logic [47:0] p,
                                input logic [8:0] e, input logic s);
        check_eq({tag, "_product"}, 64'(product_out), 64'(p));
        check_eq({tag, "_exp_sum"}, 64'(exp_sum_out), 64'(e));
        check_eq({tag, "_sign"},    64'(sign_out),    64'(s));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready_back"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        floating1_in = 32'h0;
        floating2_in = 32'h0;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  64'(in_ready),    64'd1);
        check_eq("rst_out_valid", 64'(out_valid),   64'd0);
        check_eq("rst_product",   64'(product_out), 64'd0);
        check_eq("rst_exp_sum",   64'(exp_sum_out), 64'd0);
        check_eq("rst_sign",      64'(sign_out),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 x 1.0
        accept(32'h3F800000, 32'h3F800000);
        wait_done("one_x_one");
        check_result("one_x_one", 48'h400000000000, 9'h07F, 1'b0);
        release_result("one_x_one");

        // -1.5 x 2.0, with out_ready held high through BUSY (must have no effect)
        out_ready = 1'b1;
        accept(32'hBFC00000, 32'h40000000);
        wait_done("neg_mix");
        check_result("neg_mix", 48'h600000000000, 9'h080, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("neg_mix_auto_idle", 64'(in_ready), 64'd1);

        // all-ones mantissas, then hold in DONE with ignored in_valid traffic
        accept(32'h3FFFFFFF, 32'h3FFFFFFF);
        wait_done("max_mant");
        check_result("max_mant", 48'hFFFFFE000001, 9'h07F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid     = (i % 2 == 0);
            floating1_in = 32'hC0490FDB;
            floating2_in = 32'h41200000;
            @(posedge clk);
            #1;
            check_result("hold", 48'hFFFFFE000001, 9'h07F, 1'b0);
            check_eq("hold_out_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready",  64'(in_ready),  64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result("hold");
        @(posedge clk);
        #1;
        check_eq("hold_not_captured_idle", 64'(in_ready), 64'd1);
        check_result("hold_not_captured", 48'hFFFFFE000001, 9'h07F, 1'b0);

        // zero operands: hidden bit still 1, exponent wraps
        accept(32'h00000000, 32'h00000000);
        wait_done("zero");
        check_result("zero", 48'h400000000000, 9'h181, 1'b0);
        release_result("zero");

        // reset at BUSY iteration 10
        accept(32'hBFC00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(out_valid),   64'd0);
        check_eq("abort_in_ready",  64'(in_ready),    64'd1);
        check_eq("abort_product",   64'(product_out), 64'd0);
        check_eq("abort_exp_sum",   64'(exp_sum_out), 64'd0);
        check_eq("abort_sign",      64'(sign_out),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // -3.0 x 3.0 after reset
        accept(32'hC0400000, 32'h40400000);
        wait_done("post_rst");
        check_result("post_rst", 48'h900000000000, 9'h081, 1'b1);
        release_result("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mantissa_shift_add_multiplier.md
MANTISSA_SHIFT_ADD_MULTIPLIER -- requirements
Module: mantissa_shift_add_multiplier

Interface
REQ-001 The block SHALL have these parameters:
- D_WIDTH, default 32: operand width.
- M_WIDTH, default 23: stored mantissa width.
- E_WIDTH, default 8: exponent width.
- M, default 48: product width.

REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- floating1_in  input  D_WIDTH  operand A, IEEE-754 single.
- floating2_in  input  D_WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  downstream normalizer accepts result.
- product_out  output  M  {1,mA} x {1,mB}, unnormalized.
- exp_sum_out  output  E_WIDTH+1  exponent sum with bias removed, sent to the normalizer.
- sign_out  output  1  result sign.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low, named rst_n, with clk as the clock.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 In IDLE, at a clock edge with in_valid=1, the block SHALL capture the operands and go to BUSY. It SHALL load:
- multiplicand register (M bits) = {1'b1, mA}, zero-extended.
- multiplier register (24 bits) = {1'b1, mB}.
- accumulator = 0.
- iteration counter = 0.
REQ-007 The capture edge SHALL also register the following, which stay stable until the next capture:
- sign = signA XOR signB.
- exp_sum = (expA + expB + 9'h181) mod 2^(E_WIDTH+1), i.e. expA+expB-127 with 9-bit wrap.
REQ-008 At each BUSY edge the block SHALL:
- add the multiplicand into the accumulator if multiplier bit 0 = 1 (M-bit add, no overflow possible);
- shift the multiplicand left 1;
- shift the multiplier right 1;
- increment the counter (5 bits).
REQ-009 After exactly 24 BUSY iterations the FSM SHALL go to DONE; out_valid SHALL rise 24 cycles after the capture edge.
REQ-010 In DONE, product_out, exp_sum_out and sign_out SHALL hold stable while out_ready=0, for any number of cycles.
REQ-011 At a DONE edge with out_ready=1 the FSM SHALL return to IDLE, so out_valid lasts at least one cycle.
REQ-012 Minimum initiation interval SHALL be 26 cycles, since there is no accept in DONE; in_valid in BUSY or DONE SHALL be ignored and the operands not captured.
REQ-013 Exponent and mantissa values SHALL NOT be special-cased (zero, denormal, Inf, NaN); the hidden bit SHALL always be 1.
REQ-014 Outside DONE, product_out, exp_sum_out and sign_out SHALL show the last registered values. They SHALL NOT be used while out_valid=0.
REQ-015 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-016 While rst_n=0, the block SHALL hold:
- state = IDLE, in_ready = 1, out_valid = 0;
- product_out = 0, exp_sum_out = 0, sign_out = 0;
- counter, accumulator and shift registers = 0.
REQ-017 Reset asserted mid-BUSY or in DONE SHALL abort immediately (asynchronously) with no result emitted.
REQ-018 The first capture SHALL occur at the first rising edge after rst_n deasserts with in_valid=1.

Verification
REQ-019 The bench SHALL drive 0x3F800000 x 0x3F800000. Required: product_out = 0x400000000000, exp_sum_out = 0x07F, sign_out = 0, out_valid 24 cycles after accept.
REQ-020 The bench SHALL drive 0xBFC00000 x 0x40000000. Required: product_out = 0x600000000000, exp_sum_out = 0x080, sign_out = 1.
REQ-021 The bench SHALL drive 0x3FFFFFFF x 0x3FFFFFFF. Required: product_out = 0xFFFFFE000001, exp_sum_out = 0x07F, sign_out = 0.
REQ-022 The bench SHALL drive 0x00000000 x 0x00000000. Required: product_out = 0x400000000000, exp_sum_out = 0x181 (wrap).
REQ-023 The bench SHALL hold out_ready = 0 for 10 cycles in DONE, toggle in_valid with new operands, then release. Required: outputs unchanged, in_ready = 0 throughout, return to IDLE one edge after out_ready = 1, new operands not captured.
REQ-024 The bench SHALL assert rst_n = 0 at BUSY iteration 10. Required: out_valid = 0 and all outputs 0 immediately, in_ready = 1. A new accept after release SHALL give a correct result after the full 24 cycles.
